// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer.
package run_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } seqState_t;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_OK      = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_BADSEL  = 2'd3;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int ctrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_cycle_ctr.sv
// RUN-length counter: synchronous clear, count enable, and a flag that is
// high when the increment taken this cycle will land on TIMEOUT.
module run_cycle_ctr #(
    parameter int          CYC_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CYC_W-1:0] count,
    output logic             termNext
);

    localparam logic [CYC_W-1:0] LAST_BEFORE_TC = CYC_W'(TIMEOUT - 1);

    // The sequencer leaves RUN on the cycle termNext is high, so count
    // stops at TIMEOUT and never wraps.
    assign termNext = (count == LAST_BEFORE_TC);

    // Count register; also serves directly as the held CycleCount result.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Host-side launch controller: accepts a run request, pulses CoreStart,
// measures RUN cycles until CoreAck or timeout, and reports status.
//
// state  | meaning
// IDLE   | waiting for a HostReq rising edge
// LAUNCH | CoreStart high for START_CYCLES clocks, CoreAck ignored
// RUN    | counting cycles, waiting for CoreAck or timeout
// REPORT | HostDone pulse, result valid
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int          NUM_PROGS    = 3,
    parameter int          SEL_W        = 2,
    parameter int          CYC_W        = 16,
    parameter int unsigned TIMEOUT      = 16'hFFFF,
    parameter int          START_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             HostReq,
    input  logic [SEL_W-1:0] HostProgSel,
    output logic             HostBusy,
    output logic             HostDone,
    output logic [1:0]       HostStatus,
    output logic [CYC_W-1:0] CycleCount,
    output logic             CoreStart,
    output logic [SEL_W-1:0] CoreProgSel,
    input  logic             CoreAck
);

    localparam int              SCW        = ctrWidth(START_CYCLES);
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

    seqState_t      state;
    logic           reqQ;
    logic [SCW-1:0] startCnt;
    logic           accept;
    logic           selValid;
    logic           termNext;

    assign accept   = (state == IDLE) && HostReq && !reqQ;
    assign selValid = (int'(HostProgSel) < NUM_PROGS);

    run_cycle_ctr #(
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (accept),
        .enable   (state == RUN),
        .count    (CycleCount),
        .termNext (termNext)
    );

    // Sequencer FSM with registered host and core outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            reqQ        <= 1'b1;
            startCnt    <= '0;
            HostBusy    <= 1'b0;
            HostDone    <= 1'b0;
            HostStatus  <= ST_NONE;
            CoreStart   <= 1'b0;
            CoreProgSel <= '0;
        end else begin
            reqQ     <= HostReq;
            HostDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        HostBusy <= 1'b1;
                        if (selValid) begin
                            CoreProgSel <= HostProgSel;
                            CoreStart   <= 1'b1;
                            startCnt    <= START_LAST;
                            HostStatus  <= ST_NONE;
                            state       <= LAUNCH;
                        end else begin
                            HostStatus <= ST_BADSEL;
                            HostDone   <= 1'b1;
                            state      <= REPORT;
                        end
                    end
                end
                LAUNCH: begin
                    if (startCnt == '0) begin
                        CoreStart <= 1'b0;
                        state     <= RUN;
                    end else begin
                        startCnt <= startCnt - 1'b1;
                    end
                end
                RUN: begin
                    // An Ack on the terminal cycle still counts as success.
                    if (CoreAck) begin
                        HostStatus <= ST_OK;
                        HostDone   <= 1'b1;
                        state      <= REPORT;
                    end else if (termNext) begin
                        HostStatus <= ST_TIMEOUT;
                        HostDone   <= 1'b1;
                        state      <= REPORT;
                    end
                end
                REPORT: begin
                    HostBusy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a short-timeout instance for the main
// vector table and request filtering, plus a two-clock-start instance for
// the stale-Ack case.
module tb_run_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;

    logic        aHostReq, aCoreAck;
    logic [1:0]  aHostProgSel;
    logic        aHostBusy, aHostDone, aCoreStart;
    logic [1:0]  aHostStatus, aCoreProgSel;
    logic [15:0] aCycleCount;

    logic        bHostReq, bCoreAck;
    logic [1:0]  bHostProgSel;
    logic        bHostBusy, bHostDone, bCoreStart;
    logic [1:0]  bHostStatus, bCoreProgSel;
    logic [15:0] bCycleCount;

    int checks = 0;
    int errors = 0;
    int launchesA = 0;
    int donesA = 0;
    logic aStartPrev = 1'b0;

    localparam int S_NONE = 0, S_OK = 1, S_TO = 2, S_BAD = 3;

    always #5 Clk = ~Clk;

    run_sequencer #(.NUM_PROGS(3), .SEL_W(2), .CYC_W(16), .TIMEOUT(100), .START_CYCLES(1)) dutA (
        .Clk(Clk), .Reset(Reset), .HostReq(aHostReq), .HostProgSel(aHostProgSel),
        .HostBusy(aHostBusy), .HostDone(aHostDone), .HostStatus(aHostStatus),
        .CycleCount(aCycleCount), .CoreStart(aCoreStart), .CoreProgSel(aCoreProgSel),
        .CoreAck(aCoreAck));

    run_sequencer #(.NUM_PROGS(3), .SEL_W(2), .CYC_W(16), .TIMEOUT(16'hFFFF), .START_CYCLES(2)) dutB (
        .Clk(Clk), .Reset(Reset), .HostReq(bHostReq), .HostProgSel(bHostProgSel),
        .HostBusy(bHostBusy), .HostDone(bHostDone), .HostStatus(bHostStatus),
        .CycleCount(bCycleCount), .CoreStart(bCoreStart), .CoreProgSel(bCoreProgSel),
        .CoreAck(bCoreAck));

    // Count CoreStart rising edges and HostDone pulses on instance A.
    always @(negedge Clk) begin
        aStartPrev <= aCoreStart;
        if (aCoreStart && !aStartPrev) launchesA <= launchesA + 1;
        if (aHostDone) donesA <= donesA + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        int         ackAt;     // RUN cycle on which Ack is sampled high, 0 = never
        int         expStatus;
        int         expCount;
        int         expStartW;
    } vec_t;

    vec_t vecs[7];

    // One complete request on instance A, observed at falling edges.
    task automatic runA(input logic [1:0] sel, input int ackAt, input int expStatus,
                        input int expCount, input int expStartW, input string tag);
        int startW, runCyc, waitN;
        bit done;
        logic [1:0] progSeen;
        aHostReq = 1'b0; aCoreAck = 1'b0;
        @(negedge Clk); @(negedge Clk);
        aHostProgSel = sel; aHostReq = 1'b1;
        startW = 0; runCyc = 0; waitN = 0; done = 0; progSeen = 2'd0;
        while (!done && waitN < 400) begin
            @(negedge Clk);
            waitN++;
            if (aHostDone) done = 1;
            else if (aCoreStart) begin startW++; progSeen = aCoreProgSel; end
            else if (startW > 0) begin
                runCyc++;
                if (runCyc == ackAt) aCoreAck = 1'b1;
            end
        end
        check({tag, " done seen"}, 32'(done), 1);
        check({tag, " start width"}, startW, expStartW);
        if (expStartW > 0) check({tag, " core sel"}, progSeen, sel);
        else check({tag, " badsel latency"}, waitN, 1);
        check({tag, " status"}, aHostStatus, expStatus);
        check({tag, " count"}, aCycleCount, expCount);
        aCoreAck = 1'b0; aHostReq = 1'b0;
        @(negedge Clk);
        check({tag, " done one cycle"}, aHostDone, 0);
        check({tag, " busy dropped"}, aHostBusy, 0);
        check({tag, " status held"}, aHostStatus, expStatus);
    endtask

    task automatic waitDoneA(input string tag);
        int n;
        n = 0;
        while (!aHostDone && n < 400) begin @(negedge Clk); n++; end
        check({tag, " done within bound"}, 32'(aHostDone), 1);
    endtask

    initial begin
        int base, n, startW, runCyc;
        vecs[0] = '{2'd1, 40,  S_OK,  40,  1};
        vecs[1] = '{2'd0, 1,   S_OK,  1,   1};
        vecs[2] = '{2'd2, 99,  S_OK,  99,  1};
        vecs[3] = '{2'd2, 100, S_OK,  100, 1};
        vecs[4] = '{2'd1, 0,   S_TO,  100, 1};
        vecs[5] = '{2'd3, 0,   S_BAD, 0,   0};
        vecs[6] = '{2'd0, 7,   S_OK,  7,   1};

        Reset = 1'b0;
        aHostReq = 1'b0; aHostProgSel = 2'd0; aCoreAck = 1'b0;
        bHostReq = 1'b0; bHostProgSel = 2'd0; bCoreAck = 1'b0;
        #1;
        check("reset busy", aHostBusy, 0);
        check("reset done", aHostDone, 0);
        check("reset status", aHostStatus, S_NONE);
        check("reset count", aCycleCount, 0);
        check("reset start", aCoreStart, 0);
        check("reset coresel", aCoreProgSel, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 7; i++)
            runA(vecs[i].sel, vecs[i].ackAt, vecs[i].expStatus, vecs[i].expCount,
                 vecs[i].expStartW, $sformatf("vec%0d", i));

        // HostReq held high across the end of a run launches only once.
        @(negedge Clk);
        base = launchesA;
        aHostProgSel = 2'd0; aHostReq = 1'b1;
        n = 0;
        while (!aCoreStart && n < 10) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        aCoreAck = 1'b1;
        waitDoneA("held req");
        aCoreAck = 1'b0;
        repeat (20) @(negedge Clk);
        check("held req launches", launchesA - base, 1);
        check("held req idle", aHostBusy, 0);
        aHostReq = 1'b0;
        repeat (2) @(negedge Clk);

        // A second rising edge during RUN is dropped.
        base = launchesA;
        aHostProgSel = 2'd1; aHostReq = 1'b1;
        n = 0;
        while (!aCoreStart && n < 10) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        aHostReq = 1'b0;
        @(negedge Clk);
        aHostReq = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        aCoreAck = 1'b1;
        @(negedge Clk);
        aCoreAck = 1'b0;
        check("rerequest done", aHostDone, 1);
        check("rerequest count", aCycleCount, 6);
        check("rerequest status", aHostStatus, S_OK);
        repeat (10) @(negedge Clk);
        check("rerequest launches", launchesA - base, 1);
        aHostReq = 1'b0;

        // HostReq high while reset is released must not launch.
        @(negedge Clk);
        aHostReq = 1'b1;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        base = launchesA;
        Reset = 1'b1;
        repeat (10) @(negedge Clk);
        check("req thru reset launches", launchesA - base, 0);
        check("req thru reset busy", aHostBusy, 0);
        aHostReq = 1'b0;
        repeat (2) @(negedge Clk);

        // Reset during RUN cycle 10: outputs clear at once, no HostDone.
        aHostProgSel = 2'd2; aHostReq = 1'b1;
        startW = 0; runCyc = 0; n = 0;
        while (runCyc < 10 && n < 40) begin
            @(negedge Clk); n++;
            if (aCoreStart) startW++;
            else if (startW > 0) runCyc++;
        end
        check("midrun reached cycle 10", runCyc, 10);
        base = donesA;
        Reset = 1'b0;
        #1;
        check("midrun start", aCoreStart, 0);
        check("midrun busy", aHostBusy, 0);
        check("midrun status", aHostStatus, S_NONE);
        check("midrun count", aCycleCount, 0);
        aHostReq = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        check("midrun no done", donesA - base, 0);
        runA(2'd2, 5, S_OK, 5, 1, "after reset");

        // Stale Ack held through a two-clock LAUNCH on instance B.
        bCoreAck = 1'b1; bHostProgSel = 2'd2; bHostReq = 1'b1;
        startW = 0; runCyc = 0; n = 0;
        while (!bHostDone && n < 60) begin
            @(negedge Clk); n++;
            if (bHostDone) ;
            else if (bCoreStart) startW++;
            else if (startW > 0) begin
                runCyc++;
                if (runCyc == 1) bCoreAck = 1'b0;
                if (runCyc == 5) bCoreAck = 1'b1;
            end
        end
        bCoreAck = 1'b0; bHostReq = 1'b0;
        check("stale done", bHostDone, 1);
        check("stale start width", startW, 2);
        check("stale count", bCycleCount, 5);
        check("stale status", bHostStatus, S_OK);
        check("stale coresel", bCoreProgSel, 2);
        repeat (2) @(negedge Clk);

        // Reset during LAUNCH drops CoreStart without waiting for a clock.
        bHostProgSel = 2'd1; bHostReq = 1'b1;
        n = 0;
        while (!bCoreStart && n < 10) begin @(negedge Clk); n++; end
        check("launch reached", bCoreStart, 1);
        Reset = 1'b0;
        #1;
        check("launch reset start", bCoreStart, 0);
        check("launch reset busy", bHostBusy, 0);
        bHostReq = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
